// File: rtl/game_round_ctrl.sv
// Round sequencer for a two-player game: idle -> countdown -> play,
// with respawn pauses after each kill and a game-over state that
// declares the winner. Deaths and coins are kept as 2-digit BCD.
module game_round_ctrl #(
    parameter int COUNT_TICKS   = 60,
    parameter int COUNT_START   = 3,
    parameter int RESPAWN_TICKS = 120,
    parameter int MAX_DEATHS    = 5
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic       Tick_In,
    input  logic       Start_In,
    input  logic       P1_Hit_In,
    input  logic       P2_Hit_In,
    input  logic       P1_Coin_In,
    input  logic       P2_Coin_In,
    output logic [2:0] State_Out,
    output logic       Move_Enable_Out,
    output logic       P1_Respawn_Out,
    output logic       P2_Respawn_Out,
    output logic [7:0] P1_Deaths,
    output logic [7:0] P2_Deaths,
    output logic [7:0] CoinValue_1,
    output logic [7:0] CoinValue_2,
    output logic [3:0] Countdown_Out,
    output logic [1:0] Winner_Out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_RESPAWN   = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam logic [15:0] CT_LAST = 16'(COUNT_TICKS - 1);
    localparam logic [15:0] RT_LAST = 16'(RESPAWN_TICKS - 1);
    localparam logic [3:0]  CD_INIT = 4'(COUNT_START);
    localparam logic [7:0]  MAX_D   = 8'(MAX_DEATHS);

    state_t      state, state_nxt;
    logic        start_q;
    logic        start_edge;
    logic [15:0] tick_cnt, tick_nxt;
    logic [7:0]  d1_nxt, d2_nxt, c1_nxt, c2_nxt;
    logic [3:0]  cd_nxt;
    logic [1:0]  win_nxt;
    logic        r1_nxt, r2_nxt;
    logic        over1, over2;

    // Saturating BCD increment (99 stays 99).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) return v;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD to binary so the death limit can be a plain integer parameter.
    function automatic logic [7:0] bcd_bin(input logic [7:0] v);
        return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
    endfunction

    assign start_edge = Start_In & ~start_q;
    assign State_Out  = state;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        d1_nxt    = P1_Deaths;
        d2_nxt    = P2_Deaths;
        c1_nxt    = CoinValue_1;
        c2_nxt    = CoinValue_2;
        cd_nxt    = Countdown_Out;
        win_nxt   = Winner_Out;
        r1_nxt    = 1'b0;
        r2_nxt    = 1'b0;
        over1     = 1'b0;
        over2     = 1'b0;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_nxt = S_COUNTDOWN;
                    tick_nxt  = '0;
                    d1_nxt    = '0;
                    d2_nxt    = '0;
                    c1_nxt    = '0;
                    c2_nxt    = '0;
                    win_nxt   = '0;
                    cd_nxt    = CD_INIT;
                end
            end
            S_COUNTDOWN: begin
                if (Tick_In) begin
                    if (tick_cnt == CT_LAST) begin
                        tick_nxt = '0;
                        cd_nxt   = Countdown_Out - 4'd1;
                        if (Countdown_Out == 4'd1) state_nxt = S_PLAY;
                    end else begin
                        tick_nxt = tick_cnt + 16'd1;
                    end
                end
            end
            S_PLAY: begin
                if (P1_Coin_In) c1_nxt = bcd_inc(CoinValue_1);
                if (P2_Coin_In) c2_nxt = bcd_inc(CoinValue_2);
                if (P1_Hit_In)  d1_nxt = bcd_inc(P1_Deaths);
                if (P2_Hit_In)  d2_nxt = bcd_inc(P2_Deaths);
                over1 = bcd_bin(d1_nxt) >= MAX_D;
                over2 = bcd_bin(d2_nxt) >= MAX_D;
                if (P1_Hit_In || P2_Hit_In) begin
                    tick_nxt = '0;
                    if (over1 || over2) begin
                        state_nxt = S_GAME_OVER;
                        // The winner is whoever did not reach the limit.
                        win_nxt   = {over1, over2};
                    end else begin
                        state_nxt = S_RESPAWN;
                        r1_nxt    = P1_Hit_In;
                        r2_nxt    = P2_Hit_In;
                    end
                end
            end
            S_RESPAWN: begin
                if (Tick_In) begin
                    if (tick_cnt == RT_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = S_PLAY;
                    end else begin
                        tick_nxt = tick_cnt + 16'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tick_nxt  = '0;
            end
        endcase
    end

    // State and output registers; start_q resets high so a held Start is not an edge.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state           <= S_IDLE;
            start_q         <= 1'b1;
            tick_cnt        <= '0;
            Move_Enable_Out <= 1'b0;
            P1_Respawn_Out  <= 1'b0;
            P2_Respawn_Out  <= 1'b0;
            P1_Deaths       <= '0;
            P2_Deaths       <= '0;
            CoinValue_1     <= '0;
            CoinValue_2     <= '0;
            Countdown_Out   <= '0;
            Winner_Out      <= '0;
        end else begin
            state           <= state_nxt;
            start_q         <= Start_In;
            tick_cnt        <= tick_nxt;
            Move_Enable_Out <= (state_nxt == S_PLAY);
            P1_Respawn_Out  <= r1_nxt;
            P2_Respawn_Out  <= r2_nxt;
            P1_Deaths       <= d1_nxt;
            P2_Deaths       <= d2_nxt;
            CoinValue_1     <= c1_nxt;
            CoinValue_2     <= c2_nxt;
            Countdown_Out   <= cd_nxt;
            Winner_Out      <= win_nxt;
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: integer-level game model checked every cycle,
// plus hand-computed literal expectations along a directed game script.
module tb_game_round_ctrl;

    localparam int CT  = 2;
    localparam int CS  = 3;
    localparam int RT  = 4;
    localparam int MXD = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0;
    logic       h1 = 1'b0, h2 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    logic [2:0] st;
    logic       mv, r1, r2;
    logic [7:0] d1, d2, k1, k2;
    logic [3:0] cd;
    logic [1:0] win;

    int checks = 0;
    int errors = 0;

    game_round_ctrl #(
        .COUNT_TICKS(CT), .COUNT_START(CS), .RESPAWN_TICKS(RT), .MAX_DEATHS(MXD)
    ) dut (
        .Master_Clock_In(clk), .Reset_N_In(rst_n), .Tick_In(tick), .Start_In(start),
        .P1_Hit_In(h1), .P2_Hit_In(h2), .P1_Coin_In(c1), .P2_Coin_In(c2),
        .State_Out(st), .Move_Enable_Out(mv), .P1_Respawn_Out(r1), .P2_Respawn_Out(r2),
        .P1_Deaths(d1), .P2_Deaths(d2), .CoinValue_1(k1), .CoinValue_2(k2),
        .Countdown_Out(cd), .Winner_Out(win)
    );

    always #20 clk = ~clk;

    // ---------------- behavioural model (plain integers) ----------------
    int m_state, m_cd, m_d1, m_d2, m_c1, m_c2, m_win, m_ticks;
    bit m_prev_start, m_r1, m_r2;

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_cd = 0; m_d1 = 0; m_d2 = 0; m_c1 = 0; m_c2 = 0;
            m_win = 0; m_ticks = 0; m_prev_start = 1; m_r1 = 0; m_r2 = 0;
        end else begin
            automatic bit rose = start && !m_prev_start;
            m_prev_start = start;
            m_r1 = 0;
            m_r2 = 0;
            if ((m_state == 0 || m_state == 4) && rose) begin
                m_state = 1; m_d1 = 0; m_d2 = 0; m_c1 = 0; m_c2 = 0;
                m_win = 0; m_cd = CS; m_ticks = 0;
            end else if (m_state == 1 && tick) begin
                m_ticks++;
                if (m_ticks == CT) begin
                    m_ticks = 0;
                    m_cd--;
                    if (m_cd == 0) m_state = 2;
                end
            end else if (m_state == 2) begin
                m_c1 = sat99(m_c1 + int'(c1));
                m_c2 = sat99(m_c2 + int'(c2));
                m_d1 = sat99(m_d1 + int'(h1));
                m_d2 = sat99(m_d2 + int'(h2));
                if (h1 || h2) begin
                    m_ticks = 0;
                    if (m_d1 >= MXD || m_d2 >= MXD) begin
                        m_state = 4;
                        m_win = (m_d1 >= MXD ? 2 : 0) + (m_d2 >= MXD ? 1 : 0);
                    end else begin
                        m_state = 3; m_r1 = h1; m_r2 = h2;
                    end
                end
            end else if (m_state == 3 && tick) begin
                m_ticks++;
                if (m_ticks == RT) begin
                    m_ticks = 0;
                    m_state = 2;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("state", int'(st), m_state);
        chk("move_en", int'(mv), int'(m_state == 2));
        chk("p1_respawn", int'(r1), int'(m_r1));
        chk("p2_respawn", int'(r2), int'(m_r2));
        chk("p1_deaths", int'(d1), to_bcd(m_d1));
        chk("p2_deaths", int'(d2), to_bcd(m_d2));
        chk("coin1", int'(k1), to_bcd(m_c1));
        chk("coin2", int'(k2), to_bcd(m_c2));
        chk("countdown", int'(cd), m_cd);
        chk("winner", int'(win), m_win);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse; on return the outputs reflect it.
    task automatic pulse(input bit t, input bit a, input bit b, input bit x, input bit y);
        @(negedge clk);
        tick = t; h1 = a; h2 = b; c1 = x; c2 = y;
        @(negedge clk);
        tick = 0; h1 = 0; h2 = 0; c1 = 0; c2 = 0;
    endtask

    task automatic set_start(input bit v);
        @(negedge clk);
        start = v;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    initial begin
        // Start held high through reset must not start a round.
        start = 1;
        rst_n = 0;
        idle(3);
        chk("lit_reset_state", int'(st), 0);
        chk("lit_reset_winner", int'(win), 0);
        rst_n = 1;
        idle(3);
        chk("lit_held_start_idle", int'(st), 0);

        set_start(0);
        set_start(1);
        chk("lit_cd_state", int'(st), 1);
        chk("lit_cd_start", int'(cd), 3);

        ticks(2);
        chk("lit_cd_2", int'(cd), 2);
        set_start(0);            // start edge in countdown is ignored
        set_start(1);
        chk("lit_cd_ignore_start", int'(st), 1);
        ticks(2);
        chk("lit_cd_1", int'(cd), 1);
        ticks(1);
        chk("lit_cd_still1", int'(st), 1);
        ticks(1);
        chk("lit_play_state", int'(st), 2);
        chk("lit_play_move", int'(mv), 1);
        chk("lit_play_cd0", int'(cd), 0);

        for (int i = 0; i < 10; i++) pulse(0, 0, 0, 0, 1);
        chk("lit_coin2_10", int'(k2), 'h10);

        pulse(0, 1, 0, 1, 0);    // hit and coin same cycle
        chk("lit_hit_state", int'(st), 3);
        chk("lit_hit_d1", int'(d1), 'h01);
        chk("lit_hit_c1", int'(k1), 'h01);
        chk("lit_hit_resp", int'(r1), 1);
        idle(1);
        chk("lit_resp_onecycle", int'(r1), 0);
        pulse(0, 0, 1, 0, 1);    // ignored in respawn
        chk("lit_resp_coin_ign", int'(k2), 'h10);
        chk("lit_resp_hit_ign", int'(d2), 'h00);
        ticks(3);
        chk("lit_resp_wait", int'(st), 3);
        ticks(1);
        chk("lit_resp_done", int'(st), 2);

        for (int i = 0; i < 89; i++) pulse(0, 0, 0, 0, 1);
        chk("lit_coin2_99", int'(k2), 'h99);
        pulse(0, 0, 0, 0, 1);
        chk("lit_coin2_sat", int'(k2), 'h99);

        for (int i = 0; i < 3; i++) begin
            pulse(0, 1, 0, 0, 0);
            ticks(RT);
        end
        chk("lit_d1_4", int'(d1), 'h04);
        pulse(0, 1, 1, 0, 0);
        chk("lit_go_state", int'(st), 4);
        chk("lit_go_d1", int'(d1), 'h05);
        chk("lit_go_d2", int'(d2), 'h01);
        chk("lit_go_winner", int'(win), 2'b10);
        chk("lit_go_noresp", int'({r1, r2}), 0);

        ticks(3);
        pulse(0, 1, 1, 1, 1);    // ignored in game over
        chk("lit_go_ign", int'(d2), 'h01);
        set_start(0);
        set_start(1);
        chk("lit_restart_state", int'(st), 1);
        chk("lit_restart_clr", int'(d1), 0);
        chk("lit_restart_win", int'(win), 0);

        ticks(6);
        pulse(0, 0, 1, 0, 0);
        chk("lit_p2_resp", int'(r2), 1);
        idle(1);
        @(negedge clk);
        rst_n = 0;               // reset mid-respawn with start held high
        #1;
        chk("lit_async_state", int'(st), 0);
        chk("lit_async_d2", int'(d2), 0);
        idle(2);
        rst_n = 1;
        idle(5);
        chk("lit_post_reset_idle", int'(st), 0);
        set_start(0);
        set_start(1);
        chk("lit_post_reset_start", int'(st), 1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter COUNT_TICKS, default 60: Tick_In pulses per countdown step.
REQ-002 SHALL have parameter COUNT_START, default 3: first countdown value (1-9).
REQ-003 SHALL have parameter RESPAWN_TICKS, default 120: Tick_In pulses spent in RESPAWN.
REQ-004 SHALL have parameter MAX_DEATHS, default 5: deaths that end the game (1-99, binary).
REQ-005 SHALL have port Master_Clock_In, input, 1 bit: the single clock (25 MHz).
REQ-006 SHALL have port Reset_N_In, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port Tick_In, input, 1 bit: single-cycle timebase pulse (one per frame).
REQ-008 SHALL have port Start_In, input, 1 bit: start/restart level; only its rising edge acts.
REQ-009 SHALL have ports P1_Hit_In and P2_Hit_In, input, 1 bit each: single-cycle player-killed pulses.
REQ-010 SHALL have ports P1_Coin_In and P2_Coin_In, input, 1 bit each: single-cycle coin-collected pulses.
REQ-011 SHALL have port State_Out, output, 3 bits: IDLE=0, COUNTDOWN=1, PLAY=2, RESPAWN=3, GAME_OVER=4.
REQ-012 SHALL have port Move_Enable_Out, output, 1 bit: high only in PLAY.
REQ-013 SHALL have ports P1_Respawn_Out and P2_Respawn_Out, output, 1 bit each: single-cycle respawn pulses.
REQ-014 SHALL have ports P1_Deaths and P2_Deaths, output, 8 bits each: 2-digit BCD death counts.
REQ-015 SHALL have ports CoinValue_1 and CoinValue_2, output, 8 bits each: 2-digit BCD coin counts.
REQ-016 SHALL have port Countdown_Out, output, 4 bits: current countdown digit.
REQ-017 SHALL have port Winner_Out, output, 2 bits: 00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-018 All outputs SHALL be registered; each input event SHALL be visible on the outputs one clock after the sampling edge.
REQ-019 Start edge SHALL be detected against a registered copy of Start_In; a high Start_In held through reset SHALL NOT cause a start.
REQ-020 IDLE: on Start edge -> COUNTDOWN; clear all deaths, coins and Winner_Out; load Countdown_Out=COUNT_START; clear the tick counter.
REQ-021 COUNTDOWN: on every COUNT_TICKS-th Tick_In, decrement Countdown_Out; a decrement from 1 to 0 -> PLAY.
REQ-022 PLAY: a hit pulse SHALL increment that player's deaths in BCD (09->10, saturate at 99); simultaneous hits SHALL increment both.
REQ-023 PLAY, after a hit update: if either death count now equals or exceeds MAX_DEATHS -> GAME_OVER; otherwise -> RESPAWN, with a one-cycle pulse on the respawn output of each hit player, issued in the same cycle as State_Out=RESPAWN.
REQ-024 PLAY: a coin pulse SHALL increment that player's coins in BCD, saturating at 99; a coin and a hit in the same cycle SHALL both be counted.
REQ-025 RESPAWN: hits and coins SHALL be ignored; after RESPAWN_TICKS Tick_In pulses counted from entry -> PLAY.
REQ-026 GAME_OVER: Winner_Out = 01 if only P2 reached MAX_DEATHS, 10 if only P1 did, 11 if both did in the same cycle; hits and coins SHALL be ignored.
REQ-027 GAME_OVER: on Start edge -> COUNTDOWN with the REQ-020 clearing; a Start edge in COUNTDOWN, PLAY or RESPAWN SHALL be ignored.
REQ-028 The tick counter SHALL clear on every state entry; Tick_In outside COUNTDOWN and RESPAWN SHALL have no effect.
REQ-029 Hit and coin pulses outside PLAY SHALL be ignored.
REQ-030 Undefined State_Out encodings SHALL return to IDLE on the next clock.

Reset
REQ-031 Reset_N_In low SHALL immediately set: State_Out=IDLE, Move_Enable_Out=0, respawn outputs=0, all deaths and coins=8'h00, Countdown_Out=0, Winner_Out=00, tick counter=0, Start edge register=1.
REQ-032 Reset asserted mid-game SHALL abort the round; with Start_In low after release, the block SHALL remain in IDLE.

Verification
REQ-033 Start pulse, COUNT_TICKS=2, COUNT_START=3 -> Countdown_Out steps 3,2,1 every 2 ticks; PLAY (Move_Enable_Out=1) after the 6th tick.
REQ-034 In PLAY, P1_Hit_In pulse -> P1_Deaths=8'h01, State_Out=3, P1_Respawn_Out high for exactly one cycle; PLAY after RESPAWN_TICKS ticks.
REQ-035 P1 deaths at 4, MAX_DEATHS=5, P1 and P2 hit in the same cycle -> P1_Deaths=05, P2_Deaths=01, State_Out=4, Winner_Out=10, no respawn pulses.
REQ-036 Ten P2 coin pulses in PLAY -> CoinValue_2=8'h10; coin pulses during RESPAWN leave it unchanged; 99 plus one more pulse stays 8'h99.
REQ-037 Reset asserted in RESPAWN with Start_In held high -> all outputs return to REQ-031 values and the block stays in IDLE until Start_In goes low then high.
